// File: rtl/compressor_rle.sv
// Zero-run-length packer: folds a multi-lane element stream into {run,value} units, packed UNITS per word.
// Optional words_sent/elems_taken counters are built when COMPRESSOR_RLE_STATS_EN is defined.
module compressor_rle #(
    parameter int DATA_W = 8,
    parameter int LANES  = 16,
    parameter int UNITS  = 5,
    parameter int ZR_W   = 4,
    localparam int UW    = ZR_W + DATA_W,
    localparam int CNT_W = $clog2(UNITS + 1),
    localparam int OUT_W = UNITS * UW + CNT_W + 1,
    localparam int TN_W  = $clog2(LANES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [TN_W-1:0]         in_valid_num,
    input  logic                    flush,
    output logic [TN_W-1:0]         taken_num,
    output logic [OUT_W-1:0]        out_data,
    output logic                    mem_req,
    input  logic                    mem_ack,
`ifdef COMPRESSOR_RLE_STATS_EN
    output logic [31:0]             words_sent,
    output logic [31:0]             elems_taken,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam logic [ZR_W-1:0]  RUN_MAX = '1;
    localparam logic [CNT_W-1:0] UNITS_C = CNT_W'(UNITS);
    localparam logic [TN_W-1:0]  LANES_C = TN_W'(LANES);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_WAIT_ACK,
        ST_FLUSH
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ZR_W-1:0]      r_run;
    logic [CNT_W-1:0]     r_fill;
    logic [UNITS*UW-1:0]  r_units;
    logic [OUT_W-1:0]     r_out_data;
    logic                 r_mem_req;
    logic                 r_done;
    logic                 r_flush_armed;
    logic                 r_flushing;
    logic                 r_last_sent;

    logic [TN_W-1:0]      w_nvalid;
    logic                 w_start_flush;
    logic [UNITS*UW-1:0]  w_scan_units;
    logic [CNT_W-1:0]     w_scan_fill;
    logic [ZR_W-1:0]      w_scan_run;
    logic [TN_W-1:0]      w_scan_taken;
    logic                 w_scan_full;
    logic                 w_stop;
    logic                 w_emit;
    logic [DATA_W-1:0]    w_elem;
    logic [UW-1:0]        w_unit;
    logic                 w_tail_need;
    logic                 w_tail_fits;
    logic [UNITS*UW-1:0]  w_flush_units;
    logic [CNT_W-1:0]     w_flush_fill;

    assign w_nvalid      = (in_valid_num > LANES_C) ? LANES_C : in_valid_num;
    assign w_start_flush = (r_state == ST_ACC) && (in_valid_num == '0) && flush && r_flush_armed;

    // Lane scan: stops right after the unit that fills the word so the rest stays with the source.
    always_comb begin
        w_scan_units = r_units;
        w_scan_fill  = r_fill;
        w_scan_run   = r_run;
        w_scan_taken = '0;
        w_stop       = 1'b0;
        w_emit       = 1'b0;
        w_elem       = '0;
        w_unit       = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!w_stop && (i < int'(w_nvalid))) begin
                w_elem       = in_data[i*DATA_W +: DATA_W];
                w_scan_taken = w_scan_taken + TN_W'(1);
                w_emit       = 1'b0;
                w_unit       = '0;
                if (w_elem != '0) begin
                    w_emit     = 1'b1;
                    w_unit     = {w_scan_run, w_elem};
                    w_scan_run = '0;
                end else if (w_scan_run == RUN_MAX) begin
                    w_emit     = 1'b1;
                    w_unit     = {RUN_MAX, {DATA_W{1'b0}}};
                    w_scan_run = '0;
                end else begin
                    w_scan_run = w_scan_run + ZR_W'(1);
                end
                if (w_emit) begin
                    w_scan_units[int'(w_scan_fill)*UW +: UW] = w_unit;
                    w_scan_fill = w_scan_fill + CNT_W'(1);
                    if (w_scan_fill == UNITS_C) w_stop = 1'b1;
                end
            end
        end
    end

    assign w_scan_full = (w_scan_fill == UNITS_C);

    // A pending run ends in an implicit zero value, so the tail carries run-1.
    assign w_tail_need = (r_run != '0);
    assign w_tail_fits = (r_fill < UNITS_C);

    always_comb begin
        w_flush_units = r_units;
        w_flush_fill  = r_fill;
        if (w_tail_need && w_tail_fits) begin
            w_flush_units[int'(r_fill)*UW +: UW] = {r_run - ZR_W'(1), {DATA_W{1'b0}}};
            w_flush_fill = r_fill + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ACC;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_start_flush)    w_state_next = ST_FLUSH;
                else if (w_scan_full) w_state_next = ST_WAIT_ACK;
            end
            ST_FLUSH:    w_state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (mem_ack) w_state_next = (r_flushing && !r_last_sent) ? ST_FLUSH : ST_ACC;
            end
            default:     w_state_next = ST_ACC;
        endcase
    end

    // mem_req rises with a registered word and holds it stable until the cycle mem_ack is seen high;
    // that cycle completes the transfer, and mem_ack at any other time has no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run         <= '0;
            r_fill        <= '0;
            r_units       <= '0;
            r_out_data    <= '0;
            r_mem_req     <= 1'b0;
            r_done        <= 1'b0;
            r_flush_armed <= 1'b1;
            r_flushing    <= 1'b0;
            r_last_sent   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!flush) r_flush_armed <= 1'b1;
            case (r_state)
                ST_ACC: begin
                    if (w_start_flush) begin
                        r_flush_armed <= 1'b0;
                        r_flushing    <= 1'b1;
                    end else begin
                        r_run  <= w_scan_run;
                        r_fill <= w_scan_fill;
                        if (w_scan_full) begin
                            r_out_data  <= {1'b0, w_scan_fill, w_scan_units};
                            r_mem_req   <= 1'b1;
                            r_last_sent <= 1'b0;
                            r_units     <= '0;
                        end else begin
                            r_units <= w_scan_units;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_mem_req <= 1'b1;
                    r_units   <= '0;
                    if (w_tail_need && !w_tail_fits) begin
                        r_out_data  <= {1'b0, r_fill, r_units};
                        r_last_sent <= 1'b0;
                    end else begin
                        r_out_data  <= {1'b1, w_flush_fill, w_flush_units};
                        r_last_sent <= 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_fill    <= '0;
                        if (r_flushing && r_last_sent) begin
                            r_done     <= 1'b1;
                            r_run      <= '0;
                            r_flushing <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef COMPRESSOR_RLE_STATS_EN
    logic [31:0] r_words_sent;
    logic [31:0] r_elems_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words_sent  <= '0;
            r_elems_taken <= '0;
        end else begin
            if (r_state == ST_WAIT_ACK && mem_ack) r_words_sent <= r_words_sent + 32'd1;
            r_elems_taken <= r_elems_taken + 32'(taken_num);
        end
    end

    assign words_sent  = r_words_sent;
    assign elems_taken = r_elems_taken;
`endif

    assign taken_num = (!rst && r_state == ST_ACC) ? w_scan_taken : '0;
    assign out_data  = r_out_data;
    assign mem_req   = r_mem_req;
    assign done      = r_done;
    assign busy      = (r_state != ST_ACC) || (r_fill != '0) || (r_run != '0);

endmodule

// File: tb/tb_compressor_rle.sv
// Directed bench for compressor_rle: stream source driver, acked-word monitor and per-scenario checks.
module tb_compressor_rle;

    localparam int DW  = 8;
    localparam int LN  = 16;
    localparam int TNW = 5;
    localparam int OW  = 64;

    logic            clk;
    logic            rst;
    logic [LN*DW-1:0] in_data;
    logic [TNW-1:0]  in_valid_num;
    logic            flush;
    logic [TNW-1:0]  taken_num;
    logic [OW-1:0]   out_data;
    logic            mem_req;
    logic            mem_ack;
    logic            busy;
    logic            done;
`ifdef COMPRESSOR_RLE_STATS_EN
    logic [31:0]     words_sent;
    logic [31:0]     elems_taken;
`endif

    int total = 0;
    int bad   = 0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    logic [DW-1:0] src_q[$];
    int            taken_log[$];

    compressor_rle dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid_num (in_valid_num),
        .flush        (flush),
        .taken_num    (taken_num),
        .out_data     (out_data),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
`ifdef COMPRESSOR_RLE_STATS_EN
        .words_sent   (words_sent),
        .elems_taken  (elems_taken),
`endif
        .busy         (busy),
        .done         (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    // monitor: record every word the moment it is acknowledged
    always @(negedge clk) begin
        #2;
        if (!rst && mem_req && mem_ack) got_q.push_back(out_data);
    end

    function automatic logic [OW-1:0] mk_word(input logic last, input logic [2:0] cnt,
                                              input logic [11:0] u0, input logic [11:0] u1,
                                              input logic [11:0] u2, input logic [11:0] u3,
                                              input logic [11:0] u4);
        mk_word = {last, cnt, u4, u3, u2, u1, u0};
    endfunction

    // driver: present src_q from lane 0, pop whatever the DUT takes, mem_ack held high
    task automatic feed_stream();
        int guard;
        int n;
        int tk;
        guard = 0;
        while (src_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            in_data = '0;
            n = (src_q.size() > LN) ? LN : src_q.size();
            for (int j = 0; j < n; j++) in_data[j*DW +: DW] = src_q[j];
            in_valid_num = TNW'(n);
            flush   = 1'b0;
            mem_ack = 1'b1;
            #1;
            tk = int'(taken_num);
            if (tk != 0) taken_log.push_back(tk);
            for (int j = 0; j < tk; j++) void'(src_q.pop_front());
            guard++;
        end
        total++;
        if (guard >= 200) begin
            bad++;
            $display("FAIL stream_budget got=%0d_left exp=0_left", src_q.size());
        end
    endtask

    // driver: raise flush with no data, hold it 10 cycles with mem_ack high, count done pulses
    task automatic do_flush(output int n_done, output logic busy_start, output logic busy_end);
        @(negedge clk);
        in_valid_num = '0;
        in_data      = '0;
        flush        = 1'b1;
        mem_ack      = 1'b1;
        #1;
        busy_start = busy;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        busy_end = busy;
        @(negedge clk);
        flush   = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        mem_ack      = 1'b0;
        in_valid_num = 5'd16;
        for (int j = 0; j < LN; j++) in_data[j*DW +: DW] = 8'(j + 1);
        repeat (2) @(negedge clk);
        #1;
        total++; if (taken_num !== 5'd0) begin bad++; $display("FAIL reset_taken got=%0d exp=0", taken_num); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        in_valid_num = '0;
        in_data = '0;
    endtask

    task automatic test_flush_empty();
        int nd;
        logic bs, be;
        got_q.delete(); exp_q.delete();
        exp_q.push_back(mk_word(1'b1, 3'd0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0));
        do_flush(nd, bs, be);
        total++; if (bs !== 1'b0) begin bad++; $display("FAIL empty_busy_start got=%b exp=0", bs); end
        total++; if (nd != 1) begin bad++; $display("FAIL empty_done_pulses got=%0d exp=1", nd); end
        total++; if (be !== 1'b0) begin bad++; $display("FAIL empty_busy_end got=%b exp=0", be); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL empty_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL empty_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_ramp();
        int nd;
        logic bs, be;
        int exp_tk[4] = '{5, 5, 5, 1};
        got_q.delete(); exp_q.delete(); taken_log.delete(); src_q.delete();
        for (int j = 1; j <= 16; j++) src_q.push_back(8'(j));
        exp_q.push_back(mk_word(1'b0, 3'd5, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005));
        exp_q.push_back(mk_word(1'b0, 3'd5, 12'h006, 12'h007, 12'h008, 12'h009, 12'h00A));
        exp_q.push_back(mk_word(1'b0, 3'd5, 12'h00B, 12'h00C, 12'h00D, 12'h00E, 12'h00F));
        exp_q.push_back(mk_word(1'b1, 3'd1, 12'h010, 12'h000, 12'h000, 12'h000, 12'h000));
        feed_stream();
        do_flush(nd, bs, be);
        total++; if (taken_log.size() != 4) begin bad++; $display("FAIL ramp_ntaken got=%0d exp=4", taken_log.size()); end
        for (int k = 0; k < 4 && k < taken_log.size(); k++) begin
            total++; if (taken_log[k] != exp_tk[k]) begin bad++; $display("FAIL ramp_taken%0d got=%0d exp=%0d", k, taken_log[k], exp_tk[k]); end
        end
        total++; if (bs !== 1'b1) begin bad++; $display("FAIL ramp_busy_pending got=%b exp=1", bs); end
        total++; if (nd != 1) begin bad++; $display("FAIL ramp_done_pulses got=%0d exp=1", nd); end
        total++; if (be !== 1'b0) begin bad++; $display("FAIL ramp_busy_end got=%b exp=0", be); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ramp_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL ramp_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_run_max();
        int nd;
        logic bs, be;
        got_q.delete(); exp_q.delete(); taken_log.delete(); src_q.delete();
        for (int j = 0; j < 16; j++) src_q.push_back(8'h00);
        src_q.push_back(8'h07);
        exp_q.push_back(mk_word(1'b1, 3'd2, 12'hF00, 12'h007, 12'h000, 12'h000, 12'h000));
        feed_stream();
        do_flush(nd, bs, be);
        total++; if (taken_log.size() != 2) begin bad++; $display("FAIL runmax_ntaken got=%0d exp=2", taken_log.size()); end
        if (taken_log.size() == 2) begin
            total++; if (taken_log[0] != 16) begin bad++; $display("FAIL runmax_taken0 got=%0d exp=16", taken_log[0]); end
            total++; if (taken_log[1] != 1) begin bad++; $display("FAIL runmax_taken1 got=%0d exp=1", taken_log[1]); end
        end
        total++; if (nd != 1) begin bad++; $display("FAIL runmax_done_pulses got=%0d exp=1", nd); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL runmax_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL runmax_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_tail();
        int nd;
        logic bs, be;
        got_q.delete(); exp_q.delete(); taken_log.delete(); src_q.delete();
        src_q.push_back(8'h05); src_q.push_back(8'h00); src_q.push_back(8'h00); src_q.push_back(8'h00);
        exp_q.push_back(mk_word(1'b1, 3'd2, 12'h005, 12'h200, 12'h000, 12'h000, 12'h000));
        feed_stream();
        do_flush(nd, bs, be);
        total++; if (bs !== 1'b1) begin bad++; $display("FAIL tail_busy_run got=%b exp=1", bs); end
        total++; if (nd != 1) begin bad++; $display("FAIL tail_done_pulses got=%0d exp=1", nd); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL tail_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL tail_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_overvalid();
        int nd;
        logic bs, be;
        got_q.delete(); exp_q.delete();
        exp_q.push_back(mk_word(1'b1, 3'd1, 12'hF0A, 12'h000, 12'h000, 12'h000, 12'h000));
        @(negedge clk);
        in_data = '0;
        in_data[15*DW +: DW] = 8'h0A;
        in_valid_num = 5'd20;
        mem_ack = 1'b1;
        #1;
        total++; if (taken_num !== 5'd16) begin bad++; $display("FAIL overvalid_taken got=%0d exp=16", taken_num); end
        do_flush(nd, bs, be);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL overvalid_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL overvalid_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_backpressure();
        int nd;
        logic bs, be;
        logic [OW-1:0] w_full;
        got_q.delete(); exp_q.delete();
        w_full = mk_word(1'b0, 3'd5, 12'h011, 12'h022, 12'h033, 12'h044, 12'h055);
        exp_q.push_back(w_full);
        exp_q.push_back(mk_word(1'b1, 3'd1, 12'h066, 12'h000, 12'h000, 12'h000, 12'h000));
        // stray mem_ack while accumulating
        @(negedge clk);
        in_data = '0;
        in_data[0*DW +: DW] = 8'h11; in_data[1*DW +: DW] = 8'h22;
        in_valid_num = 5'd2;
        mem_ack = 1'b1;
        #1;
        total++; if (taken_num !== 5'd2) begin bad++; $display("FAIL bp_taken_first got=%0d exp=2", taken_num); end
        @(negedge clk);
        in_data = '0;
        in_data[0*DW +: DW] = 8'h33; in_data[1*DW +: DW] = 8'h44;
        in_data[2*DW +: DW] = 8'h55; in_data[3*DW +: DW] = 8'h66;
        in_valid_num = 5'd4;
        mem_ack = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_stray_ack_req got=%b exp=0", mem_req); end
        total++; if (taken_num !== 5'd3) begin bad++; $display("FAIL bp_taken_fill got=%0d exp=3", taken_num); end
        @(negedge clk);
        in_data = '0;
        in_data[0*DW +: DW] = 8'h66;
        in_valid_num = 5'd1;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL bp_hold_req c%0d got=%b exp=1", c, mem_req); end
            total++; if (out_data !== w_full) begin bad++; $display("FAIL bp_hold_data c%0d got=%h exp=%h", c, out_data, w_full); end
            total++; if (taken_num !== 5'd0) begin bad++; $display("FAIL bp_hold_taken c%0d got=%0d exp=0", c, taken_num); end
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        total++; if (taken_num !== 5'd0) begin bad++; $display("FAIL bp_ack_cycle_taken got=%0d exp=0", taken_num); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_req_dropped got=%b exp=0", mem_req); end
        total++; if (taken_num !== 5'd1) begin bad++; $display("FAIL bp_resume_taken got=%0d exp=1", taken_num); end
        do_flush(nd, bs, be);
        total++; if (nd != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d exp=1", nd); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        logic bs, be;
        @(negedge clk);
        in_data = '0;
        for (int j = 0; j < 5; j++) in_data[j*DW +: DW] = 8'(j + 1);
        in_valid_num = 5'd5;
        mem_ack = 1'b0;
        @(negedge clk);
        in_data = '0;
        in_valid_num = '0;
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmid_req_before got=%b exp=1", mem_req); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", mem_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL rmid_out_data got=%h exp=0", out_data); end
        @(negedge clk);
        rst = 1'b0;
        got_q.delete(); exp_q.delete();
        exp_q.push_back(mk_word(1'b1, 3'd0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0));
        do_flush(nd, bs, be);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rmid_nwords got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rmid_word%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

`ifdef COMPRESSOR_RLE_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (words_sent !== 32'd0) begin bad++; $display("FAIL stats_reset_words got=%0d exp=0", words_sent); end
        @(negedge clk);
        rst = 1'b0;
        src_q.delete(); taken_log.delete();
        for (int j = 1; j <= 20; j++) src_q.push_back(8'(j));
        feed_stream();
        repeat (3) @(negedge clk);
        mem_ack = 1'b0;
        #1;
        total++; if (words_sent !== 32'd4) begin bad++; $display("FAIL stats_words got=%0d exp=4", words_sent); end
        total++; if (elems_taken !== 32'd20) begin bad++; $display("FAIL stats_elems got=%0d exp=20", elems_taken); end
    endtask
`endif

    initial begin
        test_reset();
        test_flush_empty();
        test_ramp();
        test_run_max();
        test_tail();
        test_overvalid();
        test_backpressure();
        test_reset_mid();
`ifdef COMPRESSOR_RLE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
